wb_interconnect_1xn_reg: RTL and testbench

Parametrised single-master, N-slave Wishbone interconnect with registered slave selection, a default slave for unmapped addresses, and a per-beat timeout watchdog. It is the successor to the fixed 1x4 pass-through interconnect. It sits between one bus master (CPU or DMA) and up to 16 peripheral or memory slaves. Any access that no slave claims, or that a slave never acknowledges, always terminates with ERR instead of hanging the bus.

---
 rtl/wb_interconnect_pkg.sv | 29 ++
 rtl/wb_if.sv | 28 ++
 rtl/wb_addr_decode.sv | 41 ++++
 rtl/wb_interconnect_1xn_reg.sv | 156 +++++++++++++++
 tb/tb_wb_interconnect_1xn_reg.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_interconnect_pkg.sv
// wb_interconnect_pkg: shared types and helpers for the 1xN Wishbone
// interconnect (FSM state enum, range compare, select-index width).
package wb_interconnect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DEFERR,
        ST_ABORT
    } wb_ic_state_e;

    // Widest address the range compare handles.
    localparam int ADDR_MAX_W = 64;

    // Width of the slave select index; never below one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Inclusive base/limit window test.
    function automatic logic addr_in_range(
        input logic [ADDR_MAX_W-1:0] addr,
        input logic [ADDR_MAX_W-1:0] base,
        input logic [ADDR_MAX_W-1:0] limit
    );
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/wb_if.sv
// wb_if: classic Wishbone bus bundle.
// master drives cyc/stb/we/adr/dat_w/sel/cti/bte; slave drives dat_r/ack/err.
interface wb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w;
    logic [DW-1:0] dat_r;
    logic [DW/8-1:0] sel;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic          ack;
    logic          err;

    modport master (
        output cyc, stb, we, adr, dat_w, sel, cti, bte,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel, cti, bte,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_addr_decode.sv
// wb_addr_decode: combinational address decoder over packed base/limit pairs.
// Ports: adr in; hit = some window matches; idx = lowest matching slave.
module wb_addr_decode
    import wb_interconnect_pkg::*;
#(
    parameter int AW = 32,
    parameter int N  = 4,
    parameter logic [2*N*AW-1:0] ADDR_RANGES = '0,
    localparam int SW = sel_width(N)
) (
    input  logic [AW-1:0] adr,
    output logic          hit,
    output logic [SW-1:0] idx
);

    logic [N-1:0] match;

    // Slave 0 owns the most-significant {BASE, LIMIT} pair.
    for (genvar i = 0; i < N; i++) begin : g_match
        localparam int BO = (2 * (N - 1 - i) + 1) * AW;
        localparam int LO = 2 * (N - 1 - i) * AW;
        assign match[i] = addr_in_range(
            ADDR_MAX_W'(adr),
            ADDR_MAX_W'(ADDR_RANGES[BO +: AW]),
            ADDR_MAX_W'(ADDR_RANGES[LO +: AW])
        );
    end

    // Scan high to low so the lowest matching index is the last written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit = 1'b1;
                idx = SW'(i);
            end
        end
    end

endmodule

// File: rtl/wb_interconnect_1xn_reg.sv
// wb_interconnect_1xn_reg: 1 master to N slaves with registered selection,
// default error slave for unmapped addresses and per-beat timeout watchdog.
// Ports: clk, rstn (sync, active-low), m0 (master side), s[] (slave side),
//        err_decode / err_timeout one-cycle pulses, busy = not IDLE.
module wb_interconnect_1xn_reg
    import wb_interconnect_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int N_SLAVES      = 4,
    parameter logic [2*N_SLAVES*WB_ADDR_WIDTH-1:0] ADDR_RANGES = '0,
    parameter int TIMEOUT       = 256
) (
    input  logic  clk,
    input  logic  rstn,
    wb_if.slave   m0,
    wb_if.master  s [N_SLAVES-1:0],
    output logic  err_decode,
    output logic  err_timeout,
    output logic  busy
);

    localparam int SW = sel_width(N_SLAVES);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX =
        (TIMEOUT > 0) ? CW'(TIMEOUT) : '1;

    wb_ic_state_e state;
    logic [SW-1:0] sel_q;
    logic [CW-1:0] cnt;

    logic          hit;
    logic [SW-1:0] idx;
    logic          timeout;

    logic [N_SLAVES-1:0]      s_ack;
    logic [N_SLAVES-1:0]      s_err;
    logic [WB_DATA_WIDTH-1:0] s_dat [N_SLAVES];

    logic                     sel_ack;
    logic                     sel_err;
    logic [WB_DATA_WIDTH-1:0] sel_dat;

    logic                     ack_o;
    logic                     err_o;
    logic [WB_DATA_WIDTH-1:0] dat_o;

    wb_addr_decode #(
        .AW          (WB_ADDR_WIDTH),
        .N           (N_SLAVES),
        .ADDR_RANGES (ADDR_RANGES)
    ) u_dec (
        .adr (m0.adr),
        .hit (hit),
        .idx (idx)
    );

    // Only the registered owner sees CYC/STB; everything else broadcast.
    for (genvar i = 0; i < N_SLAVES; i++) begin : g_slv
        logic own;
        assign own = (state == ST_ACTIVE) && (sel_q == SW'(i));

        assign s[i].cyc   = own & m0.cyc;
        assign s[i].stb   = own & m0.stb;
        assign s[i].we    = m0.we;
        assign s[i].adr   = m0.adr;
        assign s[i].dat_w = m0.dat_w;
        assign s[i].sel   = m0.sel;
        assign s[i].cti   = m0.cti;
        assign s[i].bte   = m0.bte;

        assign s_ack[i] = s[i].ack;
        assign s_err[i] = s[i].err;
        assign s_dat[i] = s[i].dat_r;
    end

    assign sel_ack = s_ack[sel_q];
    assign sel_err = s_err[sel_q];
    assign sel_dat = s_dat[sel_q];

    // Counter equal to TIMEOUT in ACTIVE terminates the beat this cycle.
    assign timeout = (TIMEOUT != 0)
                  && (state == ST_ACTIVE)
                  && m0.cyc
                  && (cnt == CNT_MAX);

    always_comb begin
        ack_o = 1'b0;
        err_o = 1'b0;
        dat_o = '0;
        unique case (state)
            ST_ACTIVE: begin
                ack_o = sel_ack & m0.stb;
                err_o = (sel_err & m0.stb) | timeout;
                dat_o = sel_dat;
            end
            ST_DEFERR, ST_ABORT: begin
                err_o = m0.stb;
            end
            default: begin
            end
        endcase
    end

    assign m0.ack   = ack_o;
    assign m0.err   = err_o;
    assign m0.dat_r = dat_o;

    assign err_timeout = timeout;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            sel_q      <= '0;
            cnt        <= '0;
            err_decode <= 1'b0;
        end else begin
            err_decode <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (m0.cyc && m0.stb) begin
                        sel_q <= idx;
                        cnt   <= '0;
                        if (hit) begin
                            state <= ST_ACTIVE;
                        end else begin
                            state      <= ST_DEFERR;
                            err_decode <= 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (!m0.cyc) begin
                        state <= ST_IDLE;
                    end else if (timeout) begin
                        state <= ST_ABORT;
                    end else if ((sel_ack | sel_err) & m0.stb) begin
                        cnt <= '0;
                    end else if (m0.stb && cnt != CNT_MAX) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DEFERR, ST_ABORT: begin
                    if (!m0.cyc) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_interconnect_1xn_reg.sv
// tb_wb_interconnect_1xn_reg: directed checks of routing, decode error,
// watchdog, bursts, reset abort and overlapping-range priority.
module tb_wb_interconnect_1xn_reg;

    logic clk;
    logic rstn;

    logic err_decode;
    logic err_timeout;
    logic busy;
    logic ov_err_decode;
    logic ov_err_timeout;
    logic ov_busy;

    int checks;
    int failures;

    logic [3:0] ack_en;
    logic [3:0] ack_force;
    logic [3:0] err_force;
    logic [3:0] scyc;
    logic [3:0] sstb;
    logic [1:0] ov_cyc;

    wb_if #(.AW(32), .DW(32)) m_bus ();
    wb_if #(.AW(32), .DW(32)) s_bus [3:0] ();
    wb_if #(.AW(32), .DW(32)) m_ov ();
    wb_if #(.AW(32), .DW(32)) s_ov [1:0] ();

    wb_interconnect_1xn_reg #(
        .WB_ADDR_WIDTH (32),
        .WB_DATA_WIDTH (32),
        .N_SLAVES      (4),
        .ADDR_RANGES   ({32'h0000_0000, 32'h0000_0FFF,
                         32'h0000_1000, 32'h0000_1FFF,
                         32'h0000_2000, 32'h0000_2FFF,
                         32'h0000_3000, 32'h0000_3FFF}),
        .TIMEOUT       (8)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .m0          (m_bus),
        .s           (s_bus),
        .err_decode  (err_decode),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    wb_interconnect_1xn_reg #(
        .WB_ADDR_WIDTH (32),
        .WB_DATA_WIDTH (32),
        .N_SLAVES      (2),
        .ADDR_RANGES   ({32'h0000_0000, 32'h0000_01FF,
                         32'h0000_0100, 32'h0000_02FF}),
        .TIMEOUT       (256)
    ) dut_ov (
        .clk         (clk),
        .rstn        (rstn),
        .m0          (m_ov),
        .s           (s_ov),
        .err_decode  (ov_err_decode),
        .err_timeout (ov_err_timeout),
        .busy        (ov_busy)
    );

    for (genvar i = 0; i < 4; i++) begin : g_sl
        assign s_bus[i].ack = ack_force[i]
            | (s_bus[i].cyc & s_bus[i].stb & ack_en[i]);
        assign s_bus[i].err = err_force[i]
            & s_bus[i].cyc & s_bus[i].stb;
        assign s_bus[i].dat_r = 32'hA000_0000 + i;
        assign scyc[i] = s_bus[i].cyc;
        assign sstb[i] = s_bus[i].stb;
    end

    for (genvar i = 0; i < 2; i++) begin : g_ov
        assign s_ov[i].ack   = s_ov[i].cyc & s_ov[i].stb;
        assign s_ov[i].err   = 1'b0;
        assign s_ov[i].dat_r = 32'hB000_0000 + i;
        assign ov_cyc[i]     = s_ov[i].cyc;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_idle();
        m_bus.cyc   = 1'b0;
        m_bus.stb   = 1'b0;
        m_bus.we    = 1'b0;
        m_bus.adr   = '0;
        m_bus.dat_w = '0;
        m_bus.sel   = 4'hF;
        m_bus.cti   = 3'b000;
        m_bus.bte   = 2'b00;
    endtask

    task automatic m_req(input logic [31:0] a, input logic w);
        m_bus.cyc = 1'b1;
        m_bus.stb = 1'b1;
        m_bus.we  = w;
        m_bus.adr = a;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        m_idle();
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({busy, err_decode, err_timeout} !== 3'b000) begin
            failures++;
            $display("FAIL rst_flags got=%b exp=000",
                     {busy, err_decode, err_timeout});
        end
        checks++;
        if ({scyc, sstb} !== 8'h00) begin
            failures++;
            $display("FAIL rst_slaves got=%h exp=00", {scyc, sstb});
        end
        checks++;
        if ({m_bus.ack, m_bus.err} !== 2'b00 || m_bus.dat_r !== 32'h0) begin
            failures++;
            $display("FAIL rst_master ack/err=%b dat=%h exp 00/0",
                     {m_bus.ack, m_bus.err}, m_bus.dat_r);
        end
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_write();
        tick();
        m_req(32'h0000_1004, 1'b1);
        m_bus.dat_w = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (scyc !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wr_req_cycle scyc=%b busy=%b exp 0000/0",
                     scyc, busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (scyc !== 4'b0010 || sstb !== 4'b0010) begin
            failures++;
            $display("FAIL wr_route cyc=%b stb=%b exp 0010/0010",
                     scyc, sstb);
        end
        checks++;
        if (m_bus.ack !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL wr_ack ack=%b busy=%b exp 1/1",
                     m_bus.ack, busy);
        end
        checks++;
        if (s_bus[1].dat_w !== 32'hDEAD_BEEF || s_bus[1].we !== 1'b1) begin
            failures++;
            $display("FAIL wr_data got=%h we=%b exp deadbeef/1",
                     s_bus[1].dat_w, s_bus[1].we);
        end
        tick();
        m_idle();
        @(negedge clk);
        checks++;
        if (scyc !== 4'b0000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL wr_cyc_drop scyc=%b busy=%b exp 0000/1",
                     scyc, busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wr_idle busy=%b exp 0", busy);
        end
    endtask

    task automatic test_read();
        logic [31:0] adrs [2];
        logic [3:0]  exp_cyc [2];
        logic [31:0] exp_dat [2];
        adrs[0] = 32'h0000_0008;
        adrs[1] = 32'h0000_3FFC;
        exp_cyc[0] = 4'b0001;
        exp_cyc[1] = 4'b1000;
        exp_dat[0] = 32'hA000_0000;
        exp_dat[1] = 32'hA000_0003;
        for (int k = 0; k < 2; k++) begin
            tick();
            m_req(adrs[k], 1'b0);
            tick();
            @(negedge clk);
            checks++;
            if (scyc !== exp_cyc[k] || m_bus.ack !== 1'b1
                || m_bus.dat_r !== exp_dat[k]) begin
                failures++;
                $display("FAIL rd_%0d cyc=%b ack=%b dat=%h exp %b/1/%h",
                         k, scyc, m_bus.ack, m_bus.dat_r,
                         exp_cyc[k], exp_dat[k]);
            end
            tick();
            m_idle();
            tick();
        end
    endtask

    task automatic test_decode_err();
        tick();
        m_req(32'h0000_5000, 1'b0);
        @(negedge clk);
        checks++;
        if (m_bus.err !== 1'b0 || err_decode !== 1'b0) begin
            failures++;
            $display("FAIL dec_early err=%b pulse=%b exp 0/0",
                     m_bus.err, err_decode);
        end
        tick();
        @(negedge clk);
        checks++;
        if (m_bus.err !== 1'b1 || err_decode !== 1'b1
            || m_bus.ack !== 1'b0 || m_bus.dat_r !== 32'h0) begin
            failures++;
            $display("FAIL dec_beat1 err=%b pulse=%b ack=%b dat=%h exp 1/1/0/0",
                     m_bus.err, err_decode, m_bus.ack, m_bus.dat_r);
        end
        checks++;
        if (scyc !== 4'b0000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL dec_noslave scyc=%b busy=%b exp 0000/1",
                     scyc, busy);
        end
        tick();
        m_bus.adr = 32'h0000_5004;
        @(negedge clk);
        checks++;
        if (m_bus.err !== 1'b1 || err_decode !== 1'b0 || scyc !== 4'b0) begin
            failures++;
            $display("FAIL dec_beat2 err=%b pulse=%b scyc=%b exp 1/0/0000",
                     m_bus.err, err_decode, scyc);
        end
        tick();
        m_bus.stb = 1'b0;
        @(negedge clk);
        checks++;
        if (m_bus.err !== 1'b0) begin
            failures++;
            $display("FAIL dec_nostb err=%b exp 0", m_bus.err);
        end
        tick();
        m_idle();
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL dec_exit busy=%b exp 0", busy);
        end
    endtask

    task automatic test_timeout();
        ack_en[2] = 1'b0;
        tick();
        m_req(32'h0000_2010, 1'b0);
        tick();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (m_bus.err !== 1'b0 || err_timeout !== 1'b0
                || sstb[2] !== 1'b1) begin
                failures++;
                $display("FAIL to_wait_%0d err=%b to=%b stb=%b exp 0/0/1",
                         k, m_bus.err, err_timeout, sstb[2]);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (m_bus.err !== 1'b1 || err_timeout !== 1'b1
            || sstb[2] !== 1'b1) begin
            failures++;
            $display("FAIL to_fire err=%b to=%b stb=%b exp 1/1/1",
                     m_bus.err, err_timeout, sstb[2]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (scyc !== 4'b0000 || busy !== 1'b1
            || err_timeout !== 1'b0 || m_bus.err !== 1'b1) begin
            failures++;
            $display("FAIL to_abort scyc=%b busy=%b to=%b err=%b exp 0000/1/0/1",
                     scyc, busy, err_timeout, m_bus.err);
        end
        tick();
        m_idle();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || m_bus.err !== 1'b0) begin
            failures++;
            $display("FAIL to_hold busy=%b err=%b exp 1/0", busy, m_bus.err);
        end
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL to_exit busy=%b exp 0", busy);
        end
        ack_en[2] = 1'b1;
    endtask

    task automatic test_burst();
        tick();
        m_req(32'h0000_0FF8, 1'b0);
        m_bus.cti = 3'b010;
        tick();
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            checks++;
            if (scyc !== 4'b0001 || sstb !== 4'b0001
                || m_bus.ack !== 1'b1
                || m_bus.dat_r !== 32'hA000_0000
                || s_bus[0].adr !== 32'h0000_0FF8 + 32'(4 * b)) begin
                failures++;
                $display("FAIL burst_%0d cyc=%b ack=%b dat=%h adr=%h exp 0001/1/a0000000",
                         b, scyc, m_bus.ack, m_bus.dat_r, s_bus[0].adr);
            end
            tick();
            if (b < 3) begin
                m_bus.adr = m_bus.adr + 32'd4;
                m_bus.cti = (b == 2) ? 3'b111 : 3'b010;
            end else begin
                m_idle();
            end
        end
        tick();
    endtask

    task automatic test_slave_err();
        err_force[0] = 1'b1;
        tick();
        m_req(32'h0000_0010, 1'b0);
        tick();
        @(negedge clk);
        checks++;
        if ({m_bus.ack, m_bus.err} !== 2'b11) begin
            failures++;
            $display("FAIL slv_ack_err got=%b exp 11", {m_bus.ack, m_bus.err});
        end
        tick();
        m_idle();
        err_force[0] = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        tick();
        m_req(32'h0000_1000, 1'b0);
        tick();
        tick();
        m_idle();
        tick();
        m_req(32'h0000_2000, 1'b0);
        @(negedge clk);
        checks++;
        if (scyc !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle scyc=%b busy=%b exp 0000/0", scyc, busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (scyc !== 4'b0100 || m_bus.ack !== 1'b1
            || m_bus.dat_r !== 32'hA000_0002) begin
            failures++;
            $display("FAIL b2b_second scyc=%b ack=%b dat=%h exp 0100/1/a0000002",
                     scyc, m_bus.ack, m_bus.dat_r);
        end
        tick();
        m_idle();
        tick();
    endtask

    task automatic test_reset_mid();
        ack_en[3] = 1'b0;
        tick();
        m_req(32'h0000_3000, 1'b0);
        tick();
        @(negedge clk);
        checks++;
        if (sstb[3] !== 1'b1 || m_bus.ack !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_wait stb=%b ack=%b exp 1/0",
                     sstb[3], m_bus.ack);
        end
        tick();
        rstn = 1'b0;
        tick();
        ack_force[3] = 1'b1;
        @(negedge clk);
        checks++;
        if (scyc !== 4'b0000 || sstb !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_abort cyc=%b stb=%b busy=%b exp 0000/0000/0",
                     scyc, sstb, busy);
        end
        checks++;
        if (m_bus.ack !== 1'b0 || m_bus.err !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_late ack=%b err=%b exp 0/0",
                     m_bus.ack, m_bus.err);
        end
        m_idle();
        tick();
        rstn = 1'b1;
        ack_force[3] = 1'b0;
        ack_en[3] = 1'b1;
        tick();
    endtask

    task automatic test_overlap();
        logic [31:0] adrs [2];
        logic [1:0]  exp_cyc [2];
        logic [31:0] exp_dat [2];
        adrs[0] = 32'h0000_0100;
        adrs[1] = 32'h0000_0250;
        exp_cyc[0] = 2'b01;
        exp_cyc[1] = 2'b10;
        exp_dat[0] = 32'hB000_0000;
        exp_dat[1] = 32'hB000_0001;
        for (int k = 0; k < 2; k++) begin
            tick();
            m_ov.cyc = 1'b1;
            m_ov.stb = 1'b1;
            m_ov.adr = adrs[k];
            tick();
            @(negedge clk);
            checks++;
            if (ov_cyc !== exp_cyc[k] || m_ov.ack !== 1'b1
                || m_ov.dat_r !== exp_dat[k]) begin
                failures++;
                $display("FAIL ovl_%0d cyc=%b ack=%b dat=%h exp %b/1/%h",
                         k, ov_cyc, m_ov.ack, m_ov.dat_r,
                         exp_cyc[k], exp_dat[k]);
            end
            tick();
            m_ov.cyc = 1'b0;
            m_ov.stb = 1'b0;
            tick();
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        ack_en    = 4'hF;
        ack_force = 4'h0;
        err_force = 4'h0;
        rstn      = 1'b0;
        m_idle();
        m_ov.cyc   = 1'b0;
        m_ov.stb   = 1'b0;
        m_ov.we    = 1'b0;
        m_ov.adr   = '0;
        m_ov.dat_w = '0;
        m_ov.sel   = 4'hF;
        m_ov.cti   = 3'b000;
        m_ov.bte   = 2'b00;

        test_reset();
        test_write();
        test_read();
        test_decode_err();
        test_timeout();
        test_burst();
        test_slave_err();
        test_back_to_back();
        test_reset_mid();
        test_overlap();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
